arb_prio8_ctrl: RTL and testbench

ARB_PRIO8_CTRL -- requirements
Module: arb_prio8_ctrl

---
 rtl/arb_prio8_ctrl.sv | 118 +++++++++++
 tb/tb_arb_prio8_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/arb_prio8_ctrl.sv
// arb_prio8_ctrl: 8-way arbiter with hold limit, one-cycle gap between grants.
// Ports: clk, rst_n (sync active-low), req[7:0] in; gnt[7:0], gnt_id[2:0],
// gnt_valid, timeout out (all registered).
// Macro ARB_ROUND_ROBIN_EN selects round-robin priority (default: fixed, req[7] highest).
module arb_prio8_ctrl #(
    parameter int MAX_HOLD = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);
    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
    state_t     state, state_n;
    logic [7:0] gnt_n, mask, mask_n, elig;
    logic [2:0] id_n, win;
    logic [3:0] cnt, cnt_n;
    logic       valid_n, timeout_n;
`ifdef ARB_ROUND_ROBIN_EN
    logic [2:0] ptr, ptr_n;
    // Search ascends from the slot after the last winner, wrapping at 8.
    function automatic logic [2:0] pick(input logic [7:0] r, input logic [2:0] p);
        logic [2:0] w, idx;
        logic       hit;
        w   = 3'd0;
        hit = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            idx = p + 3'(k);
            if (r[idx] && !hit) begin
                w   = idx;
                hit = 1'b1;
            end
        end
        return w;
    endfunction
    assign win = pick(elig, ptr);
    always_ff @(posedge clk)
        ptr <= !rst_n ? 3'd7 : ptr_n;
`else
    // Ascending scan lets the highest set bit win.
    function automatic logic [2:0] pick(input logic [7:0] r);
        logic [2:0] w;
        w = 3'd0;
        for (int i = 0; i < 8; i++)
            if (r[i]) w = 3'(i);
        return w;
    endfunction
    assign win = pick(elig);
`endif
    // A requester revoked by timeout is masked for the gap cycle only.
    assign elig = (state == GAP) ? (req & ~mask) : req;
    always_comb begin
        state_n   = state;
        gnt_n     = gnt;
        id_n      = gnt_id;
        valid_n   = gnt_valid;
        timeout_n = 1'b0;
        cnt_n     = cnt;
        mask_n    = mask;
`ifdef ARB_ROUND_ROBIN_EN
        ptr_n     = ptr;
`endif
        case (state)
            GRANT: begin
                if (!req[gnt_id] || cnt == 4'(MAX_HOLD)) begin
                    state_n   = GAP;
                    gnt_n     = 8'd0;
                    id_n      = 3'd0;
                    valid_n   = 1'b0;
                    timeout_n = req[gnt_id];
                    mask_n    = req[gnt_id] ? gnt : 8'd0;
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
            default: begin
                mask_n = 8'd0;
                if (|elig) begin
                    state_n = GRANT;
                    gnt_n   = 8'd1 << win;
                    id_n    = win;
                    valid_n = 1'b1;
                    cnt_n   = 4'd1;
`ifdef ARB_ROUND_ROBIN_EN
                    ptr_n   = win;
`endif
                end else begin
                    state_n = IDLE;
                    gnt_n   = 8'd0;
                    id_n    = 3'd0;
                    valid_n = 1'b0;
                end
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= 8'd0;
            gnt_id    <= 3'd0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
            cnt       <= 4'd0;
            mask      <= 8'd0;
        end else begin
            state     <= state_n;
            gnt       <= gnt_n;
            gnt_id    <= id_n;
            gnt_valid <= valid_n;
            timeout   <= timeout_n;
            cnt       <= cnt_n;
            mask      <= mask_n;
        end
    end
endmodule

// File: tb/tb_arb_prio8_ctrl.sv
// tb_arb_prio8_ctrl: directed and randomized checks against a rule-level arbiter model.
module tb_arb_prio8_ctrl;
    localparam int MH = 4;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = 8'd0;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;
    int checks = 0;
    int errors = 0;
    int owner = -1;
    int held = 0;
    int banned = -1;
    int last = 7;
    bit in_gap = 0;
    bit exp_to = 0;
    arb_prio8_ctrl #(.MAX_HOLD(MH)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt),
        .gnt_id(gnt_id), .gnt_valid(gnt_valid), .timeout(timeout)
    );
    always #5 clk = ~clk;
    function automatic int choose(input logic [7:0] r, input int lst);
`ifdef ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= 8; k++)
            if (r[(lst + k) % 8]) return (lst + k) % 8;
`else
        for (int i = 7; i >= 0; i--)
            if (r[i]) return i;
`endif
        return -1;
    endfunction
    function automatic logic [7:0] exp_gnt();
        return owner >= 0 ? 8'(1 << owner) : 8'd0;
    endfunction
    task automatic model_step();
        logic [7:0] e;
        int w;
        exp_to = 0;
        if (!rst_n) begin
            owner = -1; held = 0; banned = -1; last = 7; in_gap = 0;
        end else if (owner >= 0) begin
            if (!req[owner]) begin
                owner = -1; banned = -1; in_gap = 1;
            end else if (held == MH) begin
                banned = owner; owner = -1; in_gap = 1; exp_to = 1;
            end else begin
                held++;
            end
        end else begin
            e = req;
            if (in_gap && banned >= 0) e[banned] = 1'b0;
            w = choose(e, last);
            in_gap = 0;
            banned = -1;
            if (w >= 0) begin
                owner = w; held = 1; last = w;
            end
        end
    endtask
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask
    task automatic test_reset();
        rst_n = 1'b0;
        req = 8'hFF;
        tick();
        checks++;
        if ({gnt, gnt_id, gnt_valid, timeout} !== 13'd0) begin
            errors++;
            $display("FAIL reset: gnt=%h id=%0d v=%b to=%b want all zero", gnt, gnt_id, gnt_valid, timeout);
        end
        rst_n = 1'b1;
        req = 8'h00;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (gnt !== 8'd0 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
                errors++;
                $display("FAIL idle_c%0d: gnt=%h v=%b to=%b want 00 0 0", i, gnt, gnt_valid, timeout);
            end
        end
    endtask
    task automatic test_priority();
        logic [7:0] seq [3] = '{8'hFF, 8'h7F, 8'h7F};
        for (int i = 0; i < 3; i++) begin
            req = seq[i];
            tick();
            checks++;
            if (gnt !== exp_gnt() || gnt_id !== 3'(owner < 0 ? 0 : owner)) begin
                errors++;
                $display("FAIL priority_c%0d: gnt=%h id=%0d want gnt=%h", i, gnt, gnt_id, exp_gnt());
            end
        end
    endtask
    task automatic test_timeout();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req = 8'h01;
        for (int i = 0; i < 14; i++) begin
            tick();
            checks++;
            if (gnt !== exp_gnt() || timeout !== exp_to || gnt_valid !== (owner >= 0)) begin
                errors++;
                $display("FAIL hold_c%0d: gnt=%h to=%b v=%b want gnt=%h to=%b", i, gnt, timeout, gnt_valid, exp_gnt(), exp_to);
            end
        end
    endtask
    task automatic test_reset_mid();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req = 8'h04;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        checks++;
        if (gnt !== 8'd0 || timeout !== 1'b0 || gnt_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: gnt=%h to=%b v=%b want 00 0 0", gnt, timeout, gnt_valid);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (gnt !== 8'h04 || gnt_id !== 3'd2) begin
            errors++;
            $display("FAIL reset_release: gnt=%h id=%0d want 04 2", gnt, gnt_id);
        end
    endtask
    task automatic test_no_preempt();
        logic [7:0] seq [5] = '{8'h04, 8'h84, 8'h84, 8'h80, 8'h80};
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req = seq[i];
            tick();
            checks++;
            if (gnt !== exp_gnt() || gnt_id !== 3'(owner < 0 ? 0 : owner)) begin
                errors++;
                $display("FAIL preempt_c%0d: gnt=%h id=%0d want %h", i, gnt, gnt_id, exp_gnt());
            end
        end
    endtask
    task automatic test_rr_sweep();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req = 8'hFF;
        for (int i = 0; i < 40; i++) begin
            tick();
            checks++;
            if (gnt !== exp_gnt() || timeout !== exp_to) begin
                errors++;
                $display("FAIL sweep_c%0d: gnt=%h to=%b want %h %b", i, gnt, timeout, exp_gnt(), exp_to);
            end
        end
    endtask
    task automatic test_random();
        logic [7:0] onehot_ok;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) req = 8'($urandom) & 8'($urandom);
            rst_n = ($urandom_range(0, 49) != 0);
            tick();
            onehot_ok = gnt & (gnt - 8'd1);
            checks++;
            if (gnt !== exp_gnt() || timeout !== exp_to || gnt_valid !== (owner >= 0)
                || (owner >= 0 && gnt_id !== 3'(owner)) || (owner < 0 && gnt_id !== 3'd0)
                || onehot_ok !== 8'd0) begin
                errors++;
                $display("FAIL random_c%0d: req=%h gnt=%h id=%0d v=%b to=%b want gnt=%h to=%b",
                         i, req, gnt, gnt_id, gnt_valid, timeout, exp_gnt(), exp_to);
            end
        end
    endtask
    initial begin
        test_reset();
        test_priority();
        test_timeout();
        test_reset_mid();
        test_no_preempt();
        test_rr_sweep();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
